// File: rtl/gate_mux_scheduler.sv
// Shares one logic-gate mux between two requesters: round-robin arbitration, then the full
// mux handshake (enable, operand pulses, final ack, result wait, recycle) and a done pulse.
module gate_mux_scheduler #(
  parameter int WAIT_LIMIT = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] cmd_gate,
  input  logic [3:0] cmd_ninp,
  input  logic [7:0] cmd_ops,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       result,
  output logic [2:0] status,
  output logic       busy,
  output logic       mux_en,
  output logic [3:0] mux_gate_type,
  output logic [1:0] mux_no_of_inp,
  output logic [3:0] mux_op,
  output logic       mux_op_ack_in_pulse,
  output logic       mux_final_inp_ack,
  output logic       mux_err_clr,
  output logic       mux_reset_n,
  input  logic       mux_out,
  input  logic       mux_op_ack_out,
  input  logic       mux_time_lim_err,
  input  logic [1:0] mux_inp_num_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_START, S_FEED, S_FINAL, S_WAIT, S_RECYCLE, S_DONE
  } state_t;

  localparam logic [7:0] LIM_M1 = 8'(WAIT_LIMIT - 1);

  state_t     r_state, w_next;
  logic       r_last;
  logic [1:0] r_pcnt;
  logic [7:0] r_wcnt;
  logic [2:0] r_code, w_code;
  logic       r_res, w_res;
  logic [1:0] r_grant, r_done;
  logic       r_result, r_busy, r_mux_en, r_pulse, r_final, r_err_clr, r_mux_reset_n;
  logic [2:0] r_status;
  logic [3:0] r_gate, r_ops;
  logic [1:0] r_ninp;
  logic       w_pick, w_illegal;
  logic [3:0] w_gate, w_ops;
  logic [1:0] w_ninp;

  always_comb begin
    w_pick    = (req == 2'b11) ? ~r_last : req[1];
    w_gate    = r_grant[1] ? cmd_gate[7:4] : cmd_gate[3:0];
    w_ninp    = r_grant[1] ? cmd_ninp[3:2] : cmd_ninp[1:0];
    w_ops     = r_grant[1] ? cmd_ops[7:4]  : cmd_ops[3:0];
    w_illegal = (w_gate < 4'd2) || (w_gate > 4'd8);
  end

  always_comb begin
    w_next = r_state;
    w_code = r_code;
    w_res  = r_res;
    case (r_state)
      S_IDLE:  if (|req) w_next = S_ARB;
      S_ARB: begin
        w_code = w_illegal ? 3'b101 : 3'b000;
        w_res  = 1'b0;
        w_next = w_illegal ? S_DONE : S_START;
      end
      S_START: w_next = S_FEED;
      S_FEED:  if (r_pcnt == r_ninp) w_next = S_FINAL;
      S_FINAL: w_next = S_WAIT;
      S_WAIT: begin
        // errors outrank a simultaneous result-valid
        w_next = S_RECYCLE;
        if (mux_time_lim_err)               w_code = 3'b001;
        else if (mux_inp_num_err == 2'b10)  w_code = 3'b010;
        else if (mux_inp_num_err == 2'b01)  w_code = 3'b011;
        else if (mux_op_ack_out) begin
          w_code = 3'b000;
          w_res  = mux_out;
        end
        else if (r_wcnt == LIM_M1)          w_code = 3'b100;
        else                                w_next = S_WAIT;
      end
      S_RECYCLE: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // outputs are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b1;
      r_pcnt        <= 2'd0;
      r_wcnt        <= 8'd0;
      r_code        <= 3'd0;
      r_res         <= 1'b0;
      r_grant       <= 2'd0;
      r_done        <= 2'd0;
      r_result      <= 1'b0;
      r_status      <= 3'd0;
      r_busy        <= 1'b0;
      r_mux_en      <= 1'b0;
      r_pulse       <= 1'b0;
      r_final       <= 1'b0;
      r_err_clr     <= 1'b0;
      r_mux_reset_n <= 1'b0;
      r_gate        <= 4'd0;
      r_ninp        <= 2'd0;
      r_ops         <= 4'd0;
    end else begin
      r_state <= w_next;
      r_code  <= w_code;
      r_res   <= w_res;
      if (r_state == S_IDLE && |req) begin
        r_last  <= w_pick;
        r_grant <= w_pick ? 2'b10 : 2'b01;
      end else if (w_next == S_IDLE) begin
        r_grant <= 2'd0;
      end
      if (r_state == S_ARB) begin
        r_gate <= w_gate;
        r_ninp <= w_ninp;
        r_ops  <= w_ops;
      end else if (w_next == S_IDLE) begin
        r_gate <= 4'd0;
        r_ninp <= 2'd0;
        r_ops  <= 4'd0;
      end
      r_pcnt        <= (r_state == S_FEED) ? r_pcnt + 2'd1 : 2'd0;
      r_wcnt        <= (r_state == S_WAIT) ? r_wcnt + 8'd1 : 8'd0;
      r_busy        <= (w_next != S_IDLE);
      r_mux_en      <= (w_next == S_START);
      r_pulse       <= (w_next == S_FEED);
      r_final       <= (w_next == S_FINAL);
      r_mux_reset_n <= (w_next != S_RECYCLE);
      r_err_clr     <= (w_next == S_RECYCLE) && (w_code != 3'b000);
      r_done        <= (w_next == S_DONE) ? r_grant : 2'd0;
      r_result      <= (w_next == S_DONE) && w_res;
      r_status      <= (w_next == S_DONE) ? w_code : 3'd0;
    end
  end

  assign grant               = r_grant;
  assign done                = r_done;
  assign result              = r_result;
  assign status              = r_status;
  assign busy                = r_busy;
  assign mux_en              = r_mux_en;
  assign mux_gate_type       = r_gate;
  assign mux_no_of_inp       = r_ninp;
  assign mux_op              = r_ops;
  assign mux_op_ack_in_pulse = r_pulse;
  assign mux_final_inp_ack   = r_final;
  assign mux_err_clr         = r_err_clr;
  assign mux_reset_n         = r_mux_reset_n;

endmodule
